// File: rtl/uart_rx_frontend_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_frontend_pkg
// Purpose  : Shared defaults, receiver state encodings and debug opcodes.
// Revision : 1.0
// ============================================================================
package uart_rx_frontend_pkg;

    localparam int c_CLK_FREQ_DEFAULT = 100_000_000;
    localparam int c_BAUD_DEFAULT     = 115_200;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_BREAK  = 3'd5
    } rx_state_t;

    // Command bytes understood by the downstream debug decoder
    localparam logic [7:0] c_OP_NOP   = 8'h00;
    localparam logic [7:0] c_OP_READ  = 8'h52;
    localparam logic [7:0] c_OP_WRITE = 8'h57;
    localparam logic [7:0] c_OP_HALT  = 8'h48;
    localparam logic [7:0] c_OP_RESET = 8'h5A;

    function automatic logic even_parity(input logic [7:0] d);
        return ^d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_byte_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_byte_fifo
// Purpose  : First-word fall-through byte FIFO with a registered head output.
// Revision : 1.0
// ============================================================================
module uart_byte_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_push_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_head,
    output logic                     o_empty,
    output logic                     o_full,
    output logic [$clog2(DEPTH):0]   o_level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [LW-1:0]    r_level;
    logic [WIDTH-1:0] r_head;
    logic             w_do_pop;
    logic             w_do_push;

    assign o_empty   = (r_level == '0);
    assign o_full    = (r_level == LW'(DEPTH));
    assign o_level   = r_level;
    assign o_head    = r_head;
    // A full FIFO still accepts a push when the head leaves on the same edge
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_head   <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
            if (w_do_pop) begin
                if (r_level > LW'(1)) begin
                    r_head <= r_mem[r_rd_ptr + AW'(1)];
                end else if (w_do_push) begin
                    r_head <= i_push_data;
                end
            end else if (w_do_push && o_empty) begin
                r_head <= i_push_data;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_rx_frontend.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_frontend
// Purpose  : 8N1 UART deframer + byte FIFO; define UART_RX_PARITY_EN for 8E1.
// Revision : 1.0
// ============================================================================
module uart_rx_frontend
    import uart_rx_frontend_pkg::*;
#(
    parameter int CLK_FREQ   = c_CLK_FREQ_DEFAULT,
    parameter int BAUD       = c_BAUD_DEFAULT,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_uart_rx,
    output logic [7:0]                    o_rx_data,
    output logic                          o_rx_valid,
    input  logic                          i_rx_ready,
    output logic                          o_rx_busy,
    output logic                          o_frame_err,
    output logic                          o_overrun,
    output logic                          o_parity_err,
    output logic [$clog2(FIFO_DEPTH):0]   o_rx_level
);
    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int DLY_W        = $clog2(CLKS_PER_BIT);
    localparam logic [DLY_W-1:0] c_DLY_HALF = DLY_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [DLY_W-1:0] c_DLY_FULL = DLY_W'(CLKS_PER_BIT - 1);

    logic [1:0]       r_sync;
    logic             w_rx_s;
    rx_state_t        r_state, w_state_nxt;
    logic [DLY_W-1:0] r_dly, w_dly_nxt;
    logic [2:0]       r_bit_idx, w_bit_nxt;
    logic [7:0]       r_shift, w_shift_nxt;
    logic             r_armed;
    logic             w_push, w_frame_err;
    logic             r_push;
    logic [7:0]       r_push_data;
    logic             r_frame_err;
    logic             r_overrun;
    logic             w_fifo_empty, w_fifo_full;
`ifdef UART_RX_PARITY_EN
    logic             r_par_bad, w_par_bad_nxt;
    logic             w_parity_err, r_parity_err;
`endif

    assign w_rx_s = r_sync[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= 2'b11;
        end else begin
            r_sync <= {r_sync[0], i_uart_rx};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_dly       <= '0;
            r_bit_idx   <= '0;
            r_shift     <= '0;
            r_armed     <= 1'b0;
            r_push      <= 1'b0;
            r_push_data <= '0;
            r_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par_bad    <= 1'b0;
            r_parity_err <= 1'b0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_dly       <= w_dly_nxt;
            r_bit_idx   <= w_bit_nxt;
            r_shift     <= w_shift_nxt;
            r_armed     <= r_armed | w_rx_s;
            r_push      <= w_push;
            r_push_data <= r_shift;
            r_frame_err <= w_frame_err;
`ifdef UART_RX_PARITY_EN
            r_par_bad    <= w_par_bad_nxt;
            r_parity_err <= w_parity_err;
`endif
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_dly_nxt   = r_dly + DLY_W'(1);
        w_bit_nxt   = r_bit_idx;
        w_shift_nxt = r_shift;
        w_push      = 1'b0;
        w_frame_err = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_par_bad_nxt = r_par_bad;
        w_parity_err  = 1'b0;
`endif
        case (r_state)
            ST_IDLE: begin
                w_dly_nxt = '0;
                // A start edge only counts once the line has been seen idle
                if (!w_rx_s && r_armed) begin
                    w_state_nxt = ST_START;
                end
            end
            ST_START: begin
                if (r_dly == c_DLY_HALF) begin
                    w_dly_nxt   = '0;
                    w_bit_nxt   = '0;
                    w_state_nxt = w_rx_s ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (r_dly == c_DLY_FULL) begin
                    w_dly_nxt   = '0;
                    w_shift_nxt = {w_rx_s, r_shift[7:1]};
                    w_bit_nxt   = r_bit_idx + 3'd1;
                    if (r_bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        w_state_nxt = ST_PARITY;
`else
                        w_state_nxt = ST_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (r_dly == c_DLY_FULL) begin
                    w_dly_nxt     = '0;
                    w_par_bad_nxt = (w_rx_s != even_parity(r_shift));
                    w_parity_err  = w_par_bad_nxt;
                    w_state_nxt   = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (r_dly == c_DLY_FULL) begin
                    w_dly_nxt = '0;
                    if (w_rx_s) begin
`ifdef UART_RX_PARITY_EN
                        w_push = ~r_par_bad;
`else
                        w_push = 1'b1;
`endif
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_frame_err = 1'b1;
                        w_state_nxt = ST_BREAK;
                    end
                end
            end
            ST_BREAK: begin
                w_dly_nxt = '0;
                if (w_rx_s) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_dly_nxt   = '0;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= r_push & w_fifo_full & ~i_rx_ready;
        end
    end

    uart_byte_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (r_push),
        .i_push_data (r_push_data),
        .i_pop       (i_rx_ready),
        .o_head      (o_rx_data),
        .o_empty     (w_fifo_empty),
        .o_full      (w_fifo_full),
        .o_level     (o_rx_level)
    );

    assign o_rx_valid  = ~w_fifo_empty;
    assign o_rx_busy   = (r_state != ST_IDLE);
    assign o_frame_err = r_frame_err;
    assign o_overrun   = r_overrun;
`ifdef UART_RX_PARITY_EN
    assign o_parity_err = r_parity_err;
`else
    assign o_parity_err = 1'b0;
`endif

endmodule
`default_nettype wire
